// File: rtl/error_response_slave.sv
// Default/error slave: completes every Avalon-MM access with an error response
// and fill data, and logs each offending command into a small CSR block.
module error_response_slave #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 32,
   parameter int                BURST_W   = 4,
   parameter logic [1:0]        RESP_CODE = 2'b10,
   parameter logic [DATA_W-1:0] READ_FILL = '0,
   parameter int                CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  avs_s0_address,
   input  logic               avs_s0_read,
   input  logic               avs_s0_write,
   input  logic [DATA_W-1:0]  avs_s0_writedata,
   input  logic [BURST_W-1:0] avs_s0_burstcount,
   output logic               avs_s0_waitrequest,
   output logic [DATA_W-1:0]  avs_s0_readdata,
   output logic               avs_s0_readdatavalid,
   output logic               avs_s0_writeresponsevalid,
   output logic [1:0]         avs_s0_response,
   input  logic [1:0]         avs_csr_address,
   input  logic               avs_csr_read,
   input  logic               avs_csr_write,
   input  logic [31:0]        avs_csr_writedata,
   output logic [31:0]        avs_csr_readdata,
   output logic               irq
);

   typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_e;

   localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

   state_e               state_q, state_d;
   logic [BURST_W-1:0]   beats_q, beats_d;
   logic                 wrsp_q, wrsp_d;

   logic                 log_en, log_wr, proto_set;
   logic [BURST_W-1:0]   n_eff;

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sat_q, sat_d;
   logic                 fv_q, fv_d;
   logic                 proto_q, proto_d;
   logic [ADDR_W-1:0]    first_q, first_d;
   logic [ADDR_W-1:0]    last_addr_q, last_addr_d;
   logic                 last_wr_q, last_wr_d;
   logic                 irq_en_q, irq_en_d;
   logic [31:0]          csr_rdata_q, csr_rdata_d;
   logic [31:0]          csr_mux;
   logic                 ctrl_wr, clr;

   logic                 unused_ok;
   assign unused_ok = ^{avs_s0_writedata, avs_csr_writedata[31:2]};

   assign n_eff = (avs_s0_burstcount == '0) ? ONE : avs_s0_burstcount;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         beats_q <= '0;
         wrsp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beats_q <= beats_d;
         wrsp_q  <= wrsp_d;
      end
   end

   // ---------------- FSM: next state ----------------
   // Commands are only taken in IDLE; a simultaneous read+write is served as a read.
   always_comb begin
      state_d   = state_q;
      beats_d   = beats_q;
      wrsp_d    = 1'b0;
      log_en    = 1'b0;
      log_wr    = 1'b0;
      proto_set = 1'b0;
      case (state_q)
         IDLE: begin
            if (avs_s0_read) begin
               log_en    = 1'b1;
               proto_set = avs_s0_write;
               state_d   = RBURST;
               beats_d   = n_eff;
            end else if (avs_s0_write) begin
               log_en = 1'b1;
               log_wr = 1'b1;
               if (n_eff == ONE) begin
                  wrsp_d = 1'b1;
               end else begin
                  state_d = WBURST;
                  beats_d = n_eff - 1'b1;
               end
            end
         end
         RBURST: begin
            beats_d = beats_q - 1'b1;
            if (beats_q == ONE) state_d = IDLE;
         end
         WBURST: begin
            proto_set = avs_s0_read;
            if (avs_s0_write) begin
               beats_d = beats_q - 1'b1;
               if (beats_q == ONE) begin
                  wrsp_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      avs_s0_waitrequest        = (state_q == RBURST);
      avs_s0_readdatavalid      = (state_q == RBURST);
      avs_s0_writeresponsevalid = wrsp_q;
      avs_s0_readdata           = avs_s0_readdatavalid ? READ_FILL : '0;
      avs_s0_response           = (avs_s0_readdatavalid || wrsp_q) ? RESP_CODE : 2'b00;
   end

   // ---------------- Logging and CSR next state ----------------
   assign ctrl_wr = avs_csr_write && (avs_csr_address == 2'd3);
   assign clr     = ctrl_wr && avs_csr_writedata[1];

   // Clear is applied first so a command logged in the same cycle survives it.
   always_comb begin
      cnt_d       = clr ? '0 : cnt_q;
      sat_d       = clr ? 1'b0 : sat_q;
      fv_d        = clr ? 1'b0 : fv_q;
      proto_d     = (clr ? 1'b0 : proto_q) | proto_set;
      first_d     = clr ? '0 : first_q;
      last_addr_d = clr ? '0 : last_addr_q;
      last_wr_d   = clr ? 1'b0 : last_wr_q;
      irq_en_d    = ctrl_wr ? avs_csr_writedata[0] : irq_en_q;
      if (log_en) begin
         if (cnt_d == '1) sat_d = 1'b1;
         else             cnt_d = cnt_d + 1'b1;
         if (!fv_d) begin
            fv_d    = 1'b1;
            first_d = avs_s0_address;
         end
         last_addr_d = avs_s0_address;
         last_wr_d   = log_wr;
      end
   end

   always_comb begin
      csr_mux = '0;
      case (avs_csr_address)
         2'd0: begin
            csr_mux[0]            = fv_q;
            csr_mux[1]            = proto_q;
            csr_mux[2]            = sat_q;
            csr_mux[16 +: CNT_W]  = cnt_q;
         end
         2'd1: csr_mux[ADDR_W-1:0] = first_q;
         2'd2: begin
            csr_mux[ADDR_W-1:0] = last_addr_q;
            csr_mux[31]         = last_wr_q;
         end
         default: csr_mux[0] = irq_en_q;
      endcase
      csr_rdata_d = avs_csr_read ? csr_mux : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         fv_q        <= 1'b0;
         proto_q     <= 1'b0;
         first_q     <= '0;
         last_addr_q <= '0;
         last_wr_q   <= 1'b0;
         irq_en_q    <= 1'b0;
         csr_rdata_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         fv_q        <= fv_d;
         proto_q     <= proto_d;
         first_q     <= first_d;
         last_addr_q <= last_addr_d;
         last_wr_q   <= last_wr_d;
         irq_en_q    <= irq_en_d;
         csr_rdata_q <= csr_rdata_d;
      end
   end

   assign avs_csr_readdata = csr_rdata_q;
   assign irq              = irq_en_q & fv_q;

endmodule

// File: tb/tb_error_response_slave.sv
// Bench for error_response_slave: vector table for the main flows, hand-written
// sequences for counter saturation, clear/log collision and mid-burst reset.
module tb_error_response_slave;
   localparam logic [31:0] FILL2 = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] addr = '0;
   logic        rd = 1'b0, wr = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  bc = '0;
   logic [1:0]  ca = '0;
   logic        crd = 1'b0, cwr = 1'b0;
   logic [31:0] cwd = '0;

   logic        wait_a, rdv_a, wrv_a, irq_a;
   logic [31:0] rdata_a, csr_a;
   logic [1:0]  resp_a;
   logic        wait_b, rdv_b, wrv_b, irq_b;
   logic [31:0] rdata_b, csr_b;
   logic [1:0]  resp_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   error_response_slave dut_a (
      .clk(clk), .reset(reset),
      .avs_s0_address(addr), .avs_s0_read(rd), .avs_s0_write(wr),
      .avs_s0_writedata(wdata), .avs_s0_burstcount(bc),
      .avs_s0_waitrequest(wait_a), .avs_s0_readdata(rdata_a),
      .avs_s0_readdatavalid(rdv_a), .avs_s0_writeresponsevalid(wrv_a),
      .avs_s0_response(resp_a),
      .avs_csr_address(ca), .avs_csr_read(crd), .avs_csr_write(cwr),
      .avs_csr_writedata(cwd), .avs_csr_readdata(csr_a), .irq(irq_a)
   );

   error_response_slave #(.CNT_W(2), .READ_FILL(FILL2)) dut_b (
      .clk(clk), .reset(reset),
      .avs_s0_address(addr), .avs_s0_read(rd), .avs_s0_write(wr),
      .avs_s0_writedata(wdata), .avs_s0_burstcount(bc),
      .avs_s0_waitrequest(wait_b), .avs_s0_readdata(rdata_b),
      .avs_s0_readdatavalid(rdv_b), .avs_s0_writeresponsevalid(wrv_b),
      .avs_s0_response(resp_b),
      .avs_csr_address(ca), .avs_csr_read(crd), .avs_csr_write(cwr),
      .avs_csr_writedata(cwd), .avs_csr_readdata(csr_b), .irq(irq_b)
   );

   typedef struct {
      logic        rd, wr;
      logic [15:0] addr;
      logic [3:0]  bc;
      logic        crd, cwr;
      logic [1:0]  ca;
      logic [31:0] cwd;
      logic        e_wait, e_rdv, e_wrv, e_irq;
      logic [31:0] e_csr;
   } vec_t;

   localparam int NV = 29;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic rd_, input logic wr_, input logic [15:0] a_,
                               input logic [3:0] b_, input logic crd_, input logic cwr_,
                               input logic [1:0] ca_, input logic [31:0] cwd_,
                               input logic ew, input logic er, input logic ewr,
                               input logic ei, input logic [31:0] ec);
      vec_t v;
      v.rd = rd_; v.wr = wr_; v.addr = a_; v.bc = b_;
      v.crd = crd_; v.cwr = cwr_; v.ca = ca_; v.cwd = cwd_;
      v.e_wait = ew; v.e_rdv = er; v.e_wrv = ewr; v.e_irq = ei; v.e_csr = ec;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
      end
   endtask

   task automatic drive(input logic rd_, input logic wr_, input logic [15:0] a_,
                        input logic [3:0] b_, input logic crd_, input logic cwr_,
                        input logic [1:0] ca_, input logic [31:0] cwd_);
      rd = rd_; wr = wr_; addr = a_; bc = b_;
      crd = crd_; cwr = cwr_; ca = ca_; cwd = cwd_;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'h0, 4'd0, 1'b0, 1'b0, 2'd0, 32'h0);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " wait_a"}, 32'(wait_a), 32'h0);
      chk({tag, " rdv_a"},  32'(rdv_a),  32'h0);
      chk({tag, " wrv_a"},  32'(wrv_a),  32'h0);
      chk({tag, " resp_a"}, 32'(resp_a), 32'h0);
      chk({tag, " rdata_a"}, rdata_a,    32'h0);
      chk({tag, " csr_a"},  csr_a,       32'h0);
      chk({tag, " irq_a"},  32'(irq_a),  32'h0);
      chk({tag, " rdv_b"},  32'(rdv_b),  32'h0);
      chk({tag, " rdata_b"}, rdata_b,    32'h0);
      chk({tag, " csr_b"},  csr_b,       32'h0);
      chk({tag, " irq_b"},  32'(irq_b),  32'h0);
   endtask

   initial begin
      //            rd wr addr     bc crd cwr ca cwd      wait rdv wrv irq csr
      tbl[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
      tbl[1]  = mk(0, 0, 16'h0000, 0, 0, 1, 3, 32'h1,   0, 0, 0, 0, 32'h0);
      tbl[2]  = mk(1, 0, 16'h1234, 1, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
      tbl[3]  = mk(0, 0, 16'h0000, 0, 1, 0, 0, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[4]  = mk(0, 0, 16'h0000, 0, 1, 0, 1, 32'h0,   0, 0, 0, 1, 32'h0001_0001);
      tbl[5]  = mk(1, 0, 16'h0100, 4, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0000_1234);
      tbl[6]  = mk(0, 1, 16'h0200, 1, 0, 0, 0, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[7]  = mk(0, 1, 16'h0200, 1, 0, 0, 0, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[8]  = mk(0, 1, 16'h0200, 1, 0, 0, 0, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[9]  = mk(0, 1, 16'h0200, 1, 0, 0, 0, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[10] = mk(0, 1, 16'h0200, 1, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[11] = mk(0, 0, 16'h0000, 0, 1, 0, 0, 32'h0,   0, 0, 1, 1, 32'h0);
      tbl[12] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0003_0001);
      tbl[13] = mk(0, 1, 16'h0040, 3, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[14] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[15] = mk(0, 1, 16'h0040, 3, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[16] = mk(1, 0, 16'h0040, 3, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[17] = mk(0, 1, 16'h0040, 3, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[18] = mk(0, 0, 16'h0000, 0, 1, 0, 2, 32'h0,   0, 0, 1, 1, 32'h0);
      tbl[19] = mk(0, 0, 16'h0000, 0, 1, 0, 0, 32'h0,   0, 0, 0, 1, 32'h8000_0040);
      tbl[20] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0004_0003);
      tbl[21] = mk(1, 0, 16'h0300, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0);
      tbl[22] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[23] = mk(0, 0, 16'h0000, 0, 0, 1, 3, 32'h3,   0, 0, 0, 1, 32'h0);
      tbl[24] = mk(1, 1, 16'h0400, 1, 0, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0);
      tbl[25] = mk(0, 0, 16'h0000, 0, 1, 0, 2, 32'h0,   1, 1, 0, 1, 32'h0);
      tbl[26] = mk(0, 0, 16'h0000, 0, 1, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0000_0400);
      tbl[27] = mk(0, 0, 16'h0000, 0, 1, 0, 1, 32'h0,   0, 0, 0, 1, 32'h0001_0003);
      tbl[28] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'h0000_0400);

      idle();
      #22 reset = 1'b1;
      tick();

      // Outputs never depend combinationally on inputs, so each row's expectation
      // is what the DUT shows during the cycle that row's inputs are presented.
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].bc,
               tbl[i].crd, tbl[i].cwr, tbl[i].ca, tbl[i].cwd);
         #1;
         chk($sformatf("v%0d wait", i),  32'(wait_a), 32'(tbl[i].e_wait));
         chk($sformatf("v%0d rdv", i),   32'(rdv_a),  32'(tbl[i].e_rdv));
         chk($sformatf("v%0d wrv", i),   32'(wrv_a),  32'(tbl[i].e_wrv));
         chk($sformatf("v%0d resp", i),  32'(resp_a),
             (tbl[i].e_rdv || tbl[i].e_wrv) ? 32'h2 : 32'h0);
         chk($sformatf("v%0d rdata", i), rdata_a, 32'h0);
         chk($sformatf("v%0d csr", i),   csr_a,   tbl[i].e_csr);
         chk($sformatf("v%0d irq", i),   32'(irq_a), 32'(tbl[i].e_irq));
         chk($sformatf("v%0d rdata_b", i), rdata_b, tbl[i].e_rdv ? FILL2 : 32'h0);
         tick();
      end

      // Saturation with CNT_W=2 on dut_b, then clear colliding with a logged write.
      drive(0, 0, 16'h0, 0, 0, 1, 3, 32'h3);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 16'h0010 + 16'(i), 1, 0, 0, 0, 32'h0);
         chk($sformatf("sat wr%0d wrv", i), 32'(wrv_a), (i > 0) ? 32'h1 : 32'h0);
         tick();
      end
      drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0);
      chk("sat last wrv", 32'(wrv_a), 32'h1);
      tick();
      chk("sat status_a", csr_a, 32'h0005_0001);
      chk("sat status_b", csr_b, 32'h0003_0005);
      drive(0, 1, 16'h0016, 1, 0, 1, 3, 32'h3);
      tick();
      drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0);
      tick();
      chk("clr+log status_a", csr_a, 32'h0001_0001);
      chk("clr+log status_b", csr_b, 32'h0001_0001);
      drive(0, 0, 16'h0, 0, 1, 0, 1, 32'h0);
      tick();
      chk("clr+log first_a", csr_a, 32'h0000_0016);
      chk("clr+log first_b", csr_b, 32'h0000_0016);
      drive(0, 0, 16'h0, 0, 1, 0, 2, 32'h0);
      tick();
      chk("clr+log last_a", csr_a, 32'h8000_0016);
      chk("clr+log irq_a", 32'(irq_a), 32'h1);
      drive(0, 0, 16'h0, 0, 0, 1, 3, 32'h2);
      tick();
      chk("clr irq falls", 32'(irq_a), 32'h0);
      drive(0, 0, 16'h0, 0, 1, 0, 3, 32'h0);
      tick();
      chk("ctrl readback", csr_a, 32'h0);
      drive(0, 0, 16'h0, 0, 0, 1, 3, 32'h1);
      tick();
      chk("irq_en no fv", 32'(irq_a), 32'h0);

      // Reset asserted during beat 2 of a 4-beat read.
      drive(1, 0, 16'h0500, 4, 0, 0, 0, 32'h0);
      tick();
      drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0);
      chk("rst beat1 rdv", 32'(rdv_a), 32'h1);
      tick();
      chk("rst beat2 rdv", 32'(rdv_a), 32'h1);
      chk("rst beat2 wait", 32'(wait_a), 32'h1);
      chk("rst beat2 irq", 32'(irq_a), 32'h1);
      chk("rst beat2 csr", csr_a, 32'h0001_0001);
      #2 reset = 1'b0;
      idle();
      #1 chk_zero("in reset");
      tick();
      #2 reset = 1'b1;
      tick();
      chk("post rst wait", 32'(wait_a), 32'h0);
      chk("post rst rdv", 32'(rdv_a), 32'h0);
      drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0);
      tick();
      idle();
      chk("post rst status_a", csr_a, 32'h0);
      chk("post rst status_b", csr_b, 32'h0);
      chk("post rst irq", 32'(irq_a), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
